// File: rtl/mod_matrix_writer_if.sv
// Bus bundle between the parameter decoder (master) and the modulation
// matrix coefficient writer (slave). Optional readback signals are present
// only when MATRIX_READBACK_EN is defined.
interface mod_matrix_writer_if #(
    parameter int V_OSC   = 4,
    parameter int O_WIDTH = 2,
    parameter int ROWS    = 16,
    parameter int R_WIDTH = 4
);
    logic                               wr_valid;
    logic                               wr_ready;
    logic                               wr_bank;
    logic [R_WIDTH-1:0]                 wr_row;
    logic [O_WIDTH:0]                   wr_col;
    logic signed [7:0]                  wr_data;
    logic                               commit_req;
    logic                               clear_req;
    logic                               frame_sync;
    // Each byte is a two's-complement coefficient
    logic [ROWS-1:0][V_OSC-1:0][7:0]    mat_buf1;
    logic [ROWS-1:0][V_OSC-1:0][7:0]    mat_buf2;
    logic                               commit_busy;
    logic                               commit_done;
    logic                               wr_err;
`ifdef MATRIX_READBACK_EN
    logic                               rd_en;
    logic                               rd_live;
    logic                               rd_bank;
    logic [R_WIDTH-1:0]                 rd_row;
    logic [O_WIDTH-1:0]                 rd_col;
    logic signed [7:0]                  rd_data;
    logic                               rd_valid;
`endif

    modport master (
        output wr_valid, wr_bank, wr_row, wr_col, wr_data,
        output commit_req, clear_req, frame_sync,
`ifdef MATRIX_READBACK_EN
        output rd_en, rd_live, rd_bank, rd_row, rd_col,
        input  rd_data, rd_valid,
`endif
        input  wr_ready, mat_buf1, mat_buf2, commit_busy, commit_done, wr_err
    );

    modport slave (
        input  wr_valid, wr_bank, wr_row, wr_col, wr_data,
        input  commit_req, clear_req, frame_sync,
`ifdef MATRIX_READBACK_EN
        input  rd_en, rd_live, rd_bank, rd_row, rd_col,
        output rd_data, rd_valid,
`endif
        output wr_ready, mat_buf1, mat_buf2, commit_busy, commit_done, wr_err
    );
endinterface

// File: rtl/mod_matrix_writer.sv
// Modulation matrix coefficient writer. Host writes land in a shadow copy of
// both banks; a commit copies the whole shadow into the live banks on one
// frame_sync edge so the reader never sees a partially updated matrix.
// Optional feature macro: MATRIX_READBACK_EN (registered readback port).
module mod_matrix_writer #(
    parameter int V_OSC   = 4,
    parameter int O_WIDTH = 2,
    parameter int ROWS    = 16,
    parameter int R_WIDTH = 4
) (
    input  logic                 sCLK_XVXENVS,
    input  logic                 reset,
    mod_matrix_writer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [O_WIDTH:0]   W_COL_LIM  = (O_WIDTH + 1)'(V_OSC);
    localparam logic [R_WIDTH:0]   W_ROW_LIM  = (R_WIDTH + 1)'(ROWS);
    localparam logic [R_WIDTH-1:0] W_LAST_ROW = R_WIDTH'(ROWS - 1);

    state_t                                 r_state;
    logic [1:0][ROWS-1:0][V_OSC-1:0][7:0]   r_shadow;
    logic [ROWS-1:0][V_OSC-1:0][7:0]        r_live1;
    logic [ROWS-1:0][V_OSC-1:0][7:0]        r_live2;
    logic [R_WIDTH-1:0]                     r_clr_row;
    logic                                   r_pending;
    logic                                   r_wr_ready;
    logic                                   r_busy;
    logic                                   r_done;
    logic                                   r_err;

    logic                                   w_accept;
    logic                                   w_in_range;
    logic [O_WIDTH-1:0]                     w_col;

    assign w_accept   = bus.wr_valid && r_wr_ready;
    assign w_in_range = (bus.wr_col < W_COL_LIM) && ({1'b0, bus.wr_row} < W_ROW_LIM);
    assign w_col      = bus.wr_col[O_WIDTH-1:0];

    assign bus.wr_ready    = r_wr_ready;
    assign bus.commit_busy = r_busy;
    assign bus.commit_done = r_done;
    assign bus.wr_err      = r_err;
    assign bus.mat_buf1    = r_live1;
    assign bus.mat_buf2    = r_live2;

    // Control FSM with shadow writes, row-by-row clear and atomic commit
    always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_live1    <= '0;
            r_live2    <= '0;
            r_clr_row  <= '0;
            r_pending  <= 1'b0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_accept && !w_in_range;
            // Writes are only accepted in IDLE, so they never collide with a clear
            if (w_accept && w_in_range) begin
                r_shadow[bus.wr_bank][bus.wr_row][w_col] <= bus.wr_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        // Clear wins; a simultaneous commit is remembered for later
                        r_state    <= ST_CLEAR;
                        r_clr_row  <= '0;
                        r_pending  <= r_pending | bus.commit_req;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (bus.commit_req || r_pending) begin
                        r_state    <= ST_ARMED;
                        r_pending  <= 1'b0;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_shadow[0][r_clr_row] <= '0;
                    r_shadow[1][r_clr_row] <= '0;
                    if (bus.commit_req) begin
                        r_pending <= 1'b1;
                    end
                    if (r_clr_row == W_LAST_ROW) begin
                        r_state    <= ST_IDLE;
                        r_clr_row  <= '0;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_clr_row  <= r_clr_row + 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Entry cycle's frame_sync is never seen here, so a commit
                    // always waits for a later frame boundary
                    if (bus.frame_sync) begin
                        r_live1    <= r_shadow[0];
                        r_live2    <= r_shadow[1];
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_pending  <= 1'b0;
                    r_wr_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef MATRIX_READBACK_EN
    logic signed [7:0] r_rd_data;
    logic              r_rd_valid;

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

    // One-cycle readback of live or shadow data; a row being cleared reads its old value
    always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                if (bus.rd_live) begin
                    r_rd_data <= bus.rd_bank ? r_live2[bus.rd_row][bus.rd_col]
                                             : r_live1[bus.rd_row][bus.rd_col];
                end else begin
                    r_rd_data <= r_shadow[bus.rd_bank][bus.rd_row][bus.rd_col];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_mod_matrix_writer.sv
// Self-checking bench for mod_matrix_writer: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mod_matrix_writer;
    localparam int V_OSC   = 4;
    localparam int O_WIDTH = 2;
    localparam int ROWS    = 16;
    localparam int R_WIDTH = 4;

    typedef logic [ROWS-1:0][V_OSC-1:0][7:0] bank_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mod_matrix_writer_if #(.V_OSC(V_OSC), .O_WIDTH(O_WIDTH), .ROWS(ROWS), .R_WIDTH(R_WIDTH)) bus();

    mod_matrix_writer #(.V_OSC(V_OSC), .O_WIDTH(O_WIDTH), .ROWS(ROWS), .R_WIDTH(R_WIDTH)) dut (
        .sCLK_XVXENVS (clk),
        .reset        (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: shadow/live contents plus remaining clear cycles,
    // an armed flag and a pending-commit flag
    bank_t m_sh   [2];
    bank_t m_live [2];
    int    m_clear_left;
    bit    m_armed, m_pending, m_done, m_err;
    bit    m_check_en = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string name, input bank_t act, input bank_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sh[0] = '0; m_sh[1] = '0;
        m_live[0] = '0; m_live[1] = '0;
        m_clear_left = 0;
        m_armed = 1'b0; m_pending = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    function automatic bit model_ready();
        return (m_clear_left == 0) && !m_armed;
    endfunction

    // Apply one clock edge worth of behaviour to the model
    task automatic model_edge();
        bit rdy;
        int r;
        if (rst) return;
        rdy    = model_ready();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (bus.wr_valid && rdy) begin
            if (int'(bus.wr_col) >= V_OSC || int'(bus.wr_row) >= ROWS)
                m_err = 1'b1;
            else
                m_sh[bus.wr_bank][bus.wr_row][int'(bus.wr_col)] = bus.wr_data;
        end
        if (m_clear_left > 0) begin
            r = ROWS - m_clear_left;
            m_sh[0][r] = '0;
            m_sh[1][r] = '0;
            m_clear_left--;
            if (bus.commit_req) m_pending = 1'b1;
        end else if (m_armed) begin
            if (bus.frame_sync) begin
                m_live[0] = m_sh[0];
                m_live[1] = m_sh[1];
                m_done    = 1'b1;
                m_armed   = 1'b0;
            end
        end else if (bus.clear_req) begin
            m_clear_left = ROWS;
            if (bus.commit_req) m_pending = 1'b1;
        end else if (bus.commit_req || m_pending) begin
            m_armed   = 1'b1;
            m_pending = 1'b0;
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        if (m_check_en) begin
            chk1("wr_ready",    bus.wr_ready,    model_ready());
            chk1("commit_busy", bus.commit_busy, !model_ready());
            chk1("commit_done", bus.commit_done, m_done);
            chk1("wr_err",      bus.wr_err,      m_err);
            chk_bank("mat_buf1", bus.mat_buf1, m_live[0]);
            chk_bank("mat_buf2", bus.mat_buf2, m_live[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_bank    = 1'b0;
        bus.wr_row     = '0;
        bus.wr_col     = '0;
        bus.wr_data    = '0;
        bus.commit_req = 1'b0;
        bus.clear_req  = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic do_write(input logic bank, input logic [3:0] row, input logic [2:0] col,
                            input logic [7:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_bank  = bank;
        bus.wr_row   = row;
        bus.wr_col   = col;
        bus.wr_data  = data;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
    endtask

    initial begin
        bank_t exp_b;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        m_check_en = 1'b1;
        repeat (3) step();
        chk1("reset_ready", bus.wr_ready, 1'b1);
        chk1("reset_busy",  bus.commit_busy, 1'b0);
        rst = 1'b0;

        // Write without commit never reaches live
        do_write(1'b0, 4'd2, 3'd1, 8'hC0);
        repeat (100) step();
        chk8("nocommit_live", bus.mat_buf1[2][1], 8'h00);
        chk1("nocommit_ready", bus.wr_ready, 1'b1);

        // Commit with frame_sync ten cycles later
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk1("armed_busy", bus.commit_busy, 1'b1);
            chk8("armed_live", bus.mat_buf1[2][1], 8'h00);
            step();
        end
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
        chk8("commit_live", bus.mat_buf1[2][1], 8'hC0);
        chk1("commit_done_pulse", bus.commit_done, 1'b1);
        step();
        chk1("commit_done_end", bus.commit_done, 1'b0);
        chk1("commit_ready", bus.wr_ready, 1'b1);

        // Out-of-range column is dropped with an error pulse
        do_write(1'b0, 4'd2, 3'd4, 8'h7F);
        chk1("err_pulse", bus.wr_err, 1'b1);
        step();
        chk1("err_end", bus.wr_err, 1'b0);
        do_commit();
        exp_b = '0;
        exp_b[2][1] = 8'hC0;
        chk_bank("err_nochange", bus.mat_buf1, exp_b);

        // Fill, publish, then clear with a simultaneous commit
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < V_OSC; c++)
                    do_write(b[0], r[3:0], c[2:0], 8'h11);
        do_commit();
        chk8("fill_live", bus.mat_buf2[15][3], 8'h11);
        bus.clear_req  = 1'b1;
        bus.commit_req = 1'b1;
        step();
        bus.clear_req  = 1'b0;
        bus.commit_req = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            chk1("clear_not_ready", bus.wr_ready, 1'b0);
            step();
        end
        chk1("clear_done_idle", bus.wr_ready, 1'b1);
        step();
        chk1("pending_armed", bus.commit_busy, 1'b1);
        chk8("pre_commit_live", bus.mat_buf1[0][0], 8'h11);
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
        exp_b = '0;
        chk_bank("clear_live1", bus.mat_buf1, exp_b);
        chk_bank("clear_live2", bus.mat_buf2, exp_b);
        chk1("clear_commit_done", bus.commit_done, 1'b1);

        // Reset during ARMED discards the commit
        do_write(1'b0, 4'd0, 3'd0, 8'h22);
        do_commit();
        chk8("pre_reset_live", bus.mat_buf1[0][0], 8'h22);
        do_write(1'b1, 4'd9, 3'd3, 8'h33);
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk1("async_reset_busy", bus.commit_busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
        chk_bank("reset_live1", bus.mat_buf1, exp_b);
        chk_bank("reset_live2", bus.mat_buf2, exp_b);
        chk1("reset_no_done", bus.commit_done, 1'b0);
        chk1("reset_idle", bus.wr_ready, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.wr_valid   = ($urandom_range(0, 1) == 1);
            bus.wr_bank    = 1'($urandom_range(0, 1));
            bus.wr_row     = 4'($urandom_range(0, 15));
            bus.wr_col     = 3'($urandom_range(0, 7));
            bus.wr_data    = 8'($urandom);
            bus.commit_req = ($urandom_range(0, 19) == 0);
            bus.clear_req  = ($urandom_range(0, 59) == 0);
            bus.frame_sync = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        idle_inputs();
        step();

        m_check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
